// File: rtl/nv_blkbox_misr_collector.sv
// ---------------------------------------------------------------------------
// nv_blkbox_misr_collector
//
// Purpose:
//   Keeps a bus of spare / otherwise-unused signals alive by compacting them
//   into a multiple-input signature register (MISR) over a programmable
//   window. The input bus is folded down to SIG_W bits by XOR-ing
//   consecutive SIG_W slices. The top slice is zero-padded when DIN_W is not
//   a multiple of SIG_W. The folded word is then shifted into a Galois-style
//   MISR.
//
//   A registered single-bit XOR reduction of the live MISR feeds the
//   downstream blackbox sink. The signature captured at the end of each
//   window is offered on a valid/ready port for debug readback.
//
// Ports:
//   nvdla_core_clk  in   1      sole clock
//   nvdla_core_rst  in   1      asynchronous, active-high reset
//   din             in   DIN_W  spare signals to compact
//   start           in   1      begin a capture window (only honoured in IDLE)
//   win_len         in   WIN_W  window length in cycles, 0 means 2^WIN_W
//   clear           in   1      synchronous abort, returns to IDLE
//   sig_vld         out  1      captured signature available
//   sig_rdy         in   1      consumer accepts the signature
//   sig_data        out  SIG_W  captured signature
//   busy            out  1      FSM is not in IDLE
//   sink_bit        out  1      registered XOR-reduce of the live MISR
// ---------------------------------------------------------------------------
module nv_blkbox_misr_collector #(
  parameter int               DIN_W = 32,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h100B,
  parameter int               WIN_W = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [DIN_W-1:0] din,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             clear,
  output logic             sig_vld,
  input  logic             sig_rdy,
  output logic [SIG_W-1:0] sig_data,
  output logic             busy,
  output logic             sink_bit
);

  // Number of SIG_W slices needed to cover din; the last one may be padded.
  localparam int NSLICE = (DIN_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NSLICE * SIG_W;

  localparam logic [WIN_W-1:0] CNT_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] CNT_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [SIG_W-1:0] SIG_ZERO = {SIG_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // XOR of consecutive SIG_W slices of the input bus (zero-padded on top).
  function automatic logic [SIG_W-1:0] fold_din(input logic [DIN_W-1:0] d);
    logic [PAD_W-1:0] pad;
    logic [SIG_W-1:0] acc;
    pad            = {PAD_W{1'b0}};
    pad[DIN_W-1:0] = d;
    acc            = SIG_ZERO;
    for (int i = 0; i < NSLICE; i++) begin
      acc = acc ^ pad[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  // One MISR step: shift left, apply feedback taps when the MSB falls out,
  // then absorb the folded input word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                 input logic [SIG_W-1:0] f);
    logic [SIG_W-1:0] fb;
    if (m[SIG_W-1]) begin
      fb = POLY;
    end else begin
      fb = SIG_ZERO;
    end
    return {m[SIG_W-2:0], 1'b0} ^ fb ^ f;
  endfunction

  // Even/odd reduction of the MISR contents for the sink.
  function automatic logic parity_of(input logic [SIG_W-1:0] m);
    return ^m;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [SIG_W-1:0] misr_q,     misr_d;
  logic [WIN_W-1:0] cnt_q,      cnt_d;
  logic [SIG_W-1:0] sig_data_q, sig_data_d;
  logic             sig_vld_q,  sig_vld_d;
  logic             sink_bit_q, sink_bit_d;

  logic [SIG_W-1:0] fold_s;
  logic [SIG_W-1:0] misr_nxt_s;

  // Datapath: fold the bus and precompute the next MISR value.
  always_comb begin
    fold_s     = fold_din(din);
    misr_nxt_s = misr_step(misr_q, fold_s);
  end

  // Next-state and output logic for the IDLE/ACCUM/HOLD window controller.
  always_comb begin
    state_d    = state_q;
    misr_d     = misr_q;
    cnt_d      = cnt_q;
    sig_data_d = sig_data_q;
    sig_vld_d  = sig_vld_q;
    // The sink observes the MISR every cycle regardless of state.
    sink_bit_d = parity_of(misr_q);

    if (clear) begin
      // Abort wins over everything, including a same-cycle start. The last
      // captured signature is intentionally left in sig_data.
      state_d   = ST_IDLE;
      misr_d    = SIG_ZERO;
      cnt_d     = CNT_ZERO;
      sig_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // din is not absorbed in the start cycle; a zero win_len
            // wraps the down-counter to give a full 2^WIN_W window.
            state_d = ST_ACCUM;
            misr_d  = SIG_ZERO;
            cnt_d   = win_len;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          misr_d = misr_nxt_s;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // Last window cycle: capture the value including this cycle's din.
            sig_data_d = misr_nxt_s;
            sig_vld_d  = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          // MISR frozen; start is ignored here, even in the accept cycle.
          if (sig_vld_q && sig_rdy) begin
            sig_vld_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          misr_d    = SIG_ZERO;
          cnt_d     = CNT_ZERO;
          sig_vld_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= ST_IDLE;
      misr_q     <= SIG_ZERO;
      cnt_q      <= CNT_ZERO;
      sig_data_q <= SIG_ZERO;
      sig_vld_q  <= 1'b0;
      sink_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misr_q     <= misr_d;
      cnt_q      <= cnt_d;
      sig_data_q <= sig_data_d;
      sig_vld_q  <= sig_vld_d;
      sink_bit_q <= sink_bit_d;
    end
  end

  assign sig_vld  = sig_vld_q;
  assign sig_data = sig_data_q;
  assign sink_bit = sink_bit_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nv_blkbox_misr_collector.sv
// ---------------------------------------------------------------------------
// Testbench for nv_blkbox_misr_collector.
// A driver issues capture windows with random or directed din and pushes the
// expected signature plus its expected arrival cycle into a queue. A monitor
// pops and compares whenever sig_vld rises, and checks that the signature
// stays stable while it is held.
// ---------------------------------------------------------------------------
module tb_nv_blkbox_misr_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'd0;
  logic        start = 1'b0;
  logic [7:0]  win_len = 8'd0;
  logic        clear = 1'b0;
  logic        sig_vld;
  logic        sig_rdy = 1'b0;
  logic [15:0] sig_data;
  logic        busy;
  logic        sink_bit;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  logic [15:0] last_data = 16'h0000;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  nv_blkbox_misr_collector dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .din            (din),
    .start          (start),
    .win_len        (win_len),
    .clear          (clear),
    .sig_vld        (sig_vld),
    .sig_rdy        (sig_rdy),
    .sig_data       (sig_data),
    .busy           (busy),
    .sink_bit       (sink_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: the signature as a polynomial over GF(2) with plain
  // integer arithmetic. Multiply by x, reduce modulo x^16+x^12+x^3+x+1,
  // then add both 16-bit halves of the input word.
  function automatic logic [15:0] model_step(input logic [15:0] m, input logic [31:0] d);
    int unsigned v;
    int unsigned dv;
    v  = 32'(m) * 32'd2;
    if (v >= 32'd65536) v = (v - 32'd65536) ^ 32'h0000_100B;
    dv = 32'(d);
    v  = v ^ (dv % 32'd65536) ^ (dv / 32'd65536);
    return v[15:0];
  endfunction

  function automatic logic par16(input logic [15:0] m);
    return ($countones(m) % 2) == 1;
  endfunction

  // Monitor: cycle counter, signature scoreboard and hold-stability checks.
  initial begin
    logic        prev_vld;
    logic [15:0] prev_data;
    logic        hs;
    exp_t        e;
    prev_vld  = 1'b0;
    prev_data = 16'h0000;
    forever begin
      @(posedge clk);
      hs = sig_vld && sig_rdy;
      cyc++;
      #1;
      if (sig_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_vld: sig_vld rose with data=%0h, none expected (cycle %0d)", sig_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sig_data", 32'(sig_data), 32'(e.data));
          chk("latency", cyc, e.cyc);
        end
      end else if (sig_vld && prev_vld && !hs) begin
        chk("hold_stable", 32'(sig_data), 32'(prev_data));
      end
      prev_vld  = sig_vld;
      prev_data = sig_data;
    end
  end

  // One capture window.
  //   dmode: 0 random din, 1 din fixed to dval, 2 dval in the first cycle then zero.
  //   delay: cycles sig_rdy is held low in HOLD.
  //   mid_start: random start pulses while busy; acc_start: start in the accept cycle.
  //   do_rst: async reset mid-HOLD instead of a handshake.
  task automatic run_window(input int wl, input int dmode, input logic [31:0] dval,
                            input bit exp_en, input logic [15:0] exp_val,
                            input int delay, input bit mid_start, input bit acc_start,
                            input bit do_rst);
    logic [15:0] mh [0:256];
    logic [31:0] d;
    exp_t        e;
    int          s;
    int          n;
    n = (wl == 0) ? 256 : wl;
    @(negedge clk);
    s       = cyc;
    start   = 1'b1;
    win_len = 8'(wl);
    din     = $urandom;
    mh[0]   = 16'h0000;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = mid_start && ($urandom_range(0, 3) == 0);
      if (dmode == 1)      d = dval;
      else if (dmode == 2) d = (k == 1) ? dval : 32'd0;
      else                 d = $urandom;
      din   = d;
      mh[k] = model_step(mh[k-1], d);
      chk("busy_accum", 32'(busy), 32'd1);
      if (k >= 2) chk("sink_bit", 32'(sink_bit), 32'(par16(mh[k-2])));
      if (k == n) begin
        e.data = exp_en ? exp_val : mh[n];
        e.cyc  = s + n + 1;
        exp_q.push_back(e);
        last_data = e.data;
      end
    end
    for (int j = 0; j < delay; j++) begin
      @(negedge clk);
      start   = mid_start && ($urandom_range(0, 1) == 0);
      din     = $urandom;
      sig_rdy = 1'b0;
      chk("vld_hold", 32'(sig_vld), 32'd1);
      chk("busy_hold", 32'(busy), 32'd1);
      chk("sink_hold", 32'(sink_bit), 32'(par16((j == 0) ? mh[n-1] : mh[n])));
    end
    if (do_rst) begin
      @(negedge clk);
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_vld", 32'(sig_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(sig_data), 32'd0);
      chk("rst_sink", 32'(sink_bit), 32'd0);
      last_data = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      @(negedge clk);
      sig_rdy = 1'b1;
      start   = acc_start;
      chk("vld_before_acc", 32'(sig_vld), 32'd1);
      @(negedge clk);
      sig_rdy = 1'b0;
      start   = 1'b0;
      din     = $urandom;
      chk("vld_after_acc", 32'(sig_vld), 32'd0);
      chk("busy_after_acc", 32'(busy), 32'd0);
    end
  endtask

  // Stimulus.
  initial begin
    // Reset, then idle with random din.
    repeat (2) @(negedge clk);
    chk("in_rst_vld", 32'(sig_vld), 32'd0);
    chk("in_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      din = $urandom;
      chk("idle_vld", 32'(sig_vld), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sink", 32'(sink_bit), 32'd0);
      chk("idle_data", 32'(sig_data), 32'd0);
    end

    // Directed windows with constant expectations.
    run_window(1, 1, 32'h0000_0001, 1'b1, 16'h0001, 5, 1'b0, 1'b0, 1'b0);
    run_window(2, 1, 32'h0000_0001, 1'b1, 16'h0003, 0, 1'b0, 1'b0, 1'b0);
    run_window(4, 1, 32'h0001_0001, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1'b0);
    run_window(2, 2, 32'h0000_8000, 1'b1, 16'h100B, 2, 1'b0, 1'b0, 1'b0);

    // Clear at cycle 3 of an 8-cycle window.
    @(negedge clk);
    start   = 1'b1;
    win_len = 8'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = (k == 2);
      clear = (k == 3);
      din   = $urandom;
    end
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_data_kept", 32'(sig_data), 32'(last_data));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      din = $urandom;
      chk("clear_no_vld", 32'(sig_vld), 32'd0);
      chk("clear_sink", 32'(sink_bit), 32'd0);
    end

    // start and clear together in IDLE: no window starts.
    @(negedge clk);
    start   = 1'b1;
    clear   = 1'b1;
    win_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    chk("start_clear_busy", 32'(busy), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("start_clear_vld", 32'(sig_vld), 32'd0);
      chk("start_clear_busy2", 32'(busy), 32'd0);
    end

    // Randomized windows with stray start pulses while busy.
    for (int i = 0; i < 12; i++) begin
      run_window($urandom_range(1, 20), 0, 32'd0, 1'b0, 16'h0000,
                 $urandom_range(0, 4), 1'b1, 1'(($urandom_range(0, 1))), 1'b0);
    end

    // Full-length window (win_len = 0).
    run_window(0, 0, 32'd0, 1'b0, 16'h0000, 1, 1'b0, 1'b1, 1'b0);

    // Async reset mid-HOLD.
    run_window(5, 0, 32'd0, 1'b0, 16'h0000, 2, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_vld", 32'(sig_vld), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tot_cnt++;
      $display("FAIL missing_sig: expected data=%0h at cycle %0d never seen", e.data, e.cyc);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
